// File: rtl/id_run_counter.sv
// id_run_counter
//   Counts closed runs of identifier characters (a letter followed by one or
//   more digits) reported by an upstream recogniser through 'match'.
//   A run opens on the first valid beat with match=1 and closes on a valid
//   beat with match=0 or on flush.  Closing updates the token statistics and
//   pulses tok_done on the following cycle.
//
//   Optional feature: define ID_RUN_MAXLEN_EN to track the longest closed run
//   on max_len.  Without it max_len is tied to zero.
//
// Ports
//   clk        clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   beat qualifier for char/match
//   char       character of the current beat
//   match      recogniser status after this char (1 = inside identifier)
//   flush      end of stream, closes any open run
//   clear      synchronous clear of all counters and state (highest priority)
//   tok_done   one-cycle pulse, a run closed on the previous beat
//   tok_cnt    number of closed runs, saturating
//   last_len   length of the most recently closed run
//   last_char  final character of the most recently closed run
//   max_len    longest closed run since reset/clear (0 if feature disabled)
module id_run_counter #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       char,
   input  logic             match,
   input  logic             flush,
   input  logic             clear,
   output logic             tok_done,
   output logic [CNT_W-1:0] tok_cnt,
   output logic [LEN_W-1:0] last_len,
   output logic [7:0]       last_char,
   output logic [LEN_W-1:0] max_len
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [LEN_W-1:0] run_len;
   logic [7:0]       cand_char;

   logic             beat_hit;
   logic [LEN_W-1:0] run_inc;
   logic             close;
   logic [LEN_W-1:0] close_len;
   logic [7:0]       close_char;

   assign beat_hit = in_valid & match;
   assign run_inc  = (run_len == '1) ? run_len : run_len + LEN_ONE;

   // A matching beat arriving together with flush is folded into the run
   // before it closes, so the closing length/char may come from this beat.
   always_comb begin
      close      = 1'b0;
      close_len  = run_len;
      close_char = cand_char;
      if (state == RUN) begin
         if (beat_hit) begin
            close_len  = run_inc;
            close_char = char;
         end
         close = flush | (in_valid & ~match);
      end else if (flush & beat_hit) begin
         close      = 1'b1;
         close_len  = LEN_ONE;
         close_char = char;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         run_len   <= '0;
         cand_char <= '0;
         tok_done  <= 1'b0;
         tok_cnt   <= '0;
         last_len  <= '0;
         last_char <= '0;
`ifdef ID_RUN_MAXLEN_EN
         max_len   <= '0;
`endif
      end else if (clear) begin
         state     <= IDLE;
         run_len   <= '0;
         cand_char <= '0;
         tok_done  <= 1'b0;
         tok_cnt   <= '0;
         last_len  <= '0;
         last_char <= '0;
`ifdef ID_RUN_MAXLEN_EN
         max_len   <= '0;
`endif
      end else begin
         tok_done <= close;
         if (close) begin
            // The closing beat never opens a new run; the next match=1 beat does.
            state     <= IDLE;
            run_len   <= '0;
            last_len  <= close_len;
            last_char <= close_char;
            if (tok_cnt != '1) begin
               tok_cnt <= tok_cnt + CNT_ONE;
            end
`ifdef ID_RUN_MAXLEN_EN
            if (close_len > max_len) begin
               max_len <= close_len;
            end
`endif
         end else if (beat_hit) begin
            state     <= RUN;
            run_len   <= (state == RUN) ? run_inc : LEN_ONE;
            cand_char <= char;
         end
      end
   end

`ifndef ID_RUN_MAXLEN_EN
   assign max_len = '0;
`endif

endmodule

// File: tb/tb_id_run_counter.sv
// Self-checking bench for id_run_counter.  Two instances share stimulus:
// 'dut' with default widths and 'dut_s' with CNT_W=2 to exercise token
// counter saturation.
module tb_id_run_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] char = 8'h00;
   logic       match = 1'b0;
   logic       flush = 1'b0;
   logic       clear = 1'b0;

   logic        tok_done;
   logic [15:0] tok_cnt;
   logic [7:0]  last_len;
   logic [7:0]  last_char;
   logic [7:0]  max_len;

   logic        s_done;
   logic [1:0]  s_cnt;
   logic [7:0]  s_len;
   logic [7:0]  s_char;
   logic [7:0]  s_max;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_run_counter #(.CNT_W(16), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(char),
      .match(match), .flush(flush), .clear(clear),
      .tok_done(tok_done), .tok_cnt(tok_cnt), .last_len(last_len),
      .last_char(last_char), .max_len(max_len)
   );

   id_run_counter #(.CNT_W(2), .LEN_W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(char),
      .match(match), .flush(flush), .clear(clear),
      .tok_done(s_done), .tok_cnt(s_cnt), .last_len(s_len),
      .last_char(s_char), .max_len(s_max)
   );

   typedef struct {
      logic       v;
      logic [7:0] ch;
      logic       m;
      logic       fl;
      logic       cl;
      int         done;
      int         cnt;
      int         len;
      int         lch;
      int         mx;
   } vec_t;

   vec_t vt[$];

   function automatic void add(logic v, logic [7:0] ch, logic m, logic fl, logic cl,
                               int done, int cnt, int len, int lch, int mx);
      vec_t e;
      e.v = v; e.ch = ch; e.m = m; e.fl = fl; e.cl = cl;
      e.done = done; e.cnt = cnt; e.len = len; e.lch = lch; e.mx = mx;
      vt.push_back(e);
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int exp_max(int mx);
`ifdef ID_RUN_MAXLEN_EN
      return mx;
`else
      return 0 * mx;
`endif
   endfunction

   task automatic chk_all(string tag, int done, int cnt, int len, int lch, int mx);
      chk({tag, ".tok_done"},  int'(tok_done),  done);
      chk({tag, ".tok_cnt"},   int'(tok_cnt),   cnt);
      chk({tag, ".last_len"},  int'(last_len),  len);
      chk({tag, ".last_char"}, int'(last_char), lch);
      chk({tag, ".max_len"},   int'(max_len),   exp_max(mx));
      chk({tag, ".s_done"},    int'(s_done),    done);
      chk({tag, ".s_cnt"},     int'(s_cnt),     (cnt > 3) ? 3 : cnt);
      chk({tag, ".s_len"},     int'(s_len),     len);
      chk({tag, ".s_char"},    int'(s_char),    lch);
      chk({tag, ".s_max"},     int'(s_max),     exp_max(mx));
   endtask

   task automatic step(logic v, logic [7:0] ch, logic m, logic fl, logic cl);
      @(negedge clk);
      in_valid = v; char = ch; match = m; flush = fl; clear = cl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // a 1 2 ' ' -> one run of length 2 ending in '2'
      add(1, "a", 0, 0, 0, 0, 0, 0, 0,   0);
      add(1, "1", 1, 0, 0, 0, 0, 0, 0,   0);
      add(1, "2", 1, 0, 0, 0, 0, 0, 0,   0);
      add(1, " ", 0, 0, 0, 1, 1, 2, "2", 2);
      add(0, "#", 1, 0, 0, 0, 1, 2, "2", 2);
      // x 9 then flush without a beat
      add(1, "x", 0, 0, 0, 0, 1, 2, "2", 2);
      add(1, "9", 1, 0, 0, 0, 1, 2, "2", 2);
      add(0, "Q", 1, 1, 0, 1, 2, 1, "9", 2);
      add(0, "Q", 0, 0, 0, 0, 2, 1, "9", 2);
      // flush in IDLE: no beat, non-matching beat, matching beat
      add(0, "q", 1, 1, 0, 0, 2, 1, "9", 2);
      add(1, "z", 0, 1, 0, 0, 2, 1, "9", 2);
      add(1, "k", 1, 1, 0, 1, 3, 1, "k", 2);
      // clear beats a matching beat
      add(1, "m", 1, 0, 1, 0, 0, 0, 0,   0);
      add(0, "m", 1, 0, 0, 0, 0, 0, 0,   0);
      // runs of 3, 5 (with idle gap), 2
      add(1, "A", 1, 0, 0, 0, 0, 0, 0,   0);
      add(1, "B", 1, 0, 0, 0, 0, 0, 0,   0);
      add(1, "C", 1, 0, 0, 0, 0, 0, 0,   0);
      add(1, "-", 0, 0, 0, 1, 1, 3, "C", 3);
      add(1, "D", 1, 0, 0, 0, 1, 3, "C", 3);
      add(1, "E", 1, 0, 0, 0, 1, 3, "C", 3);
      add(0, "*", 0, 0, 0, 0, 1, 3, "C", 3);
      add(1, "F", 1, 0, 0, 0, 1, 3, "C", 3);
      add(1, "G", 1, 0, 0, 0, 1, 3, "C", 3);
      add(1, "H", 1, 0, 0, 0, 1, 3, "C", 3);
      add(1, ".", 0, 0, 0, 1, 2, 5, "H", 5);
      add(1, "I", 1, 0, 0, 0, 2, 5, "H", 5);
      add(1, "J", 1, 0, 0, 0, 2, 5, "H", 5);
      add(1, ";", 0, 0, 0, 1, 3, 2, "J", 5);
      // flush in RUN with a matching beat counts it
      add(1, "K", 1, 0, 0, 0, 3, 2, "J", 5);
      add(1, "L", 1, 1, 0, 1, 4, 2, "L", 5);
      // flush in RUN with a non-matching beat
      add(1, "M", 1, 0, 0, 0, 4, 2, "L", 5);
      add(1, "N", 0, 1, 0, 1, 5, 1, "M", 5);
      // back-to-back: closing beat does not open, next match does
      add(1, "P", 1, 0, 0, 0, 5, 1, "M", 5);
      add(1, " ", 0, 0, 0, 1, 6, 1, "P", 5);
      add(1, "Q", 1, 0, 0, 0, 6, 1, "P", 5);
      add(1, "R", 0, 0, 0, 1, 7, 1, "Q", 5);
      add(0, "R", 0, 0, 0, 0, 7, 1, "Q", 5);

      #1;
      chk_all("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         step(vt[i].v, vt[i].ch, vt[i].m, vt[i].fl, vt[i].cl);
         chk_all($sformatf("vec%0d", i), vt[i].done, vt[i].cnt, vt[i].len, vt[i].lch, vt[i].mx);
      end

      // 300 matching beats saturate the run length at 255
      step(0, 8'h00, 0, 0, 1);
      chk_all("sat_clear", 0, 0, 0, 0, 0);
      for (int unsigned k = 0; k < 300; k++) begin
         step(1, "7", 1, 0, 0);
      end
      chk("sat_run.tok_done", int'(tok_done), 0);
      step(1, "+", 0, 0, 0);
      chk_all("sat_close", 1, 1, 255, "7", 255);

      // reset in the middle of a 4-long run discards it
      for (int unsigned k = 0; k < 4; k++) begin
         step(1, "w", 1, 0, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, "!", 0, 0, 0);
      chk_all("rst_release", 0, 0, 0, 0, 0);

      // clear together with flush in RUN suppresses the close
      step(1, "a", 1, 0, 0);
      step(1, " ", 0, 0, 0);
      chk_all("pre_clear", 1, 1, 1, "a", 1);
      step(1, "b", 1, 0, 0);
      step(1, "c", 1, 0, 0);
      step(1, "d", 0, 1, 1);
      chk_all("clear_flush", 0, 0, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      chk_all("after_clear", 0, 0, 0, 0, 0);
      step(1, "e", 0, 0, 0);
      chk_all("idle_after_clear", 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_run_counter.md
ID_RUN_COUNTER -- requirements
Module: id_run_counter

Interface
REQ-001 Parameter CNT_W, default 16: width of token counter.
REQ-002 Parameter LEN_W, default 8: width of run-length registers.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  beat qualifier for char/match; no beat when 0.
REQ-006 char  input  8  ASCII character of current beat.
REQ-007 match  input  1  identifier-recogniser status after this char (1 = trailing text is letter followed by one or more digits).
REQ-008 flush  input  1  end-of-stream; closes any open run.
REQ-009 clear  input  1  synchronous clear of counters and state.
REQ-010 tok_done  output  1  one-cycle pulse: a run just closed.
REQ-011 tok_cnt  output  CNT_W  number of closed runs, saturating.
REQ-012 last_len  output  LEN_W  length of most recently closed run.
REQ-013 last_char  output  8  final char of most recently closed run.
REQ-014 max_len  output  LEN_W  longest closed run since reset/clear.

Function
REQ-015 FSM states IDLE and RUN; run_len internal register LEN_W wide.
REQ-016 IDLE, valid beat with match=1: go RUN, run_len=1, capture char as candidate last char.
REQ-017 RUN, valid beat with match=1: stay RUN, run_len+1 saturating at 2^LEN_W-1, update candidate char.
REQ-018 RUN, valid beat with match=0: close run, go IDLE.
REQ-019 Close run: next cycle tok_done=1, tok_cnt+1 (saturate at 2^CNT_W-1), last_len=run_len, last_char=candidate.
REQ-020 All outputs registered; tok_done asserted exactly the cycle after the closing beat, deasserted otherwise.
REQ-021 in_valid=0: state, run_len, outputs hold; tok_done=0 unless REQ-019 pending.
REQ-022 flush in RUN: close run as REQ-019 regardless of in_valid; beat in same cycle with match=1 is counted into run_len before closing.
REQ-023 flush in IDLE with match=1 beat: open and close single-length run (last_len=1).
REQ-024 flush in IDLE otherwise: no effect.
REQ-025 clear has priority over all beats and flush: state IDLE, run_len, tok_cnt, last_len, last_char, max_len to 0, tok_done 0 next cycle.
REQ-026 Back-to-back: closing beat (match=0) never opens a new run; next match=1 beat opens it.

Reset
REQ-027 rst_n low: immediately state IDLE, run_len=0, tok_done=0, tok_cnt=0, last_len=0, last_char=0, max_len=0.
REQ-028 Reset mid-run discards open run; no tok_done after release.
REQ-029 First beat sampled on first posedge with rst_n high.

Configuration
REQ-030 Macro ID_RUN_MAXLEN_EN defined: max_len updated on close to max(max_len, closed run_len), same cycle as last_len.
REQ-031 Macro ID_RUN_MAXLEN_EN undefined: no max-tracking logic; max_len constant 0; all else identical.

Verification
REQ-032 Beats "a","1","2"," " with match 0,1,1,0 -> tok_done pulse cycle after " ", tok_cnt=1, last_len=2, last_char="2".
REQ-033 Beats "x","9" match 0,1 then flush with in_valid=0 -> tok_done next cycle, last_len=1, last_char="9".
REQ-034 Runs of length 3 then 5 then 2 -> tok_cnt=3, last_len=2, max_len=5 (macro on) / 0 (macro off).
REQ-035 300 consecutive match=1 beats then match=0 -> last_len=255 (LEN_W=8); CNT_W=2 with 5 runs -> tok_cnt=3.
REQ-036 rst_n low during run of length 4, released, then match=0 beat -> no tok_done, tok_cnt=0; clear with flush same cycle -> tok_done stays 0.
